// File: rtl/cmos_pll_ctrl.sv
// Power-up and lock sequencer for the camera-clock PLL, clocked by the PLL reference clock.
// It pulses the PLL reset, waits for a stable lock, then enables the clock and releases camera reset.
module cmos_pll_ctrl #(
    parameter int unsigned RST_CYCLES    = 100,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned EN_TO_RST     = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock_i,
    input  logic       relock_req_i,
    output logic       pll_reset_o,
    output logic       pll_enclk_o,
    output logic       cam_rst_n_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic       lost_lock_o,
    output logic [3:0] retry_cnt_o
);

    typedef enum logic [2:0] {
        StRstPll,
        StWaitLock,
        StStable,
        StRun,
        StFail
    } state_e;

    // The WAIT_LOCK cycle that first sees lock counts as the first stable cycle.
    localparam int unsigned StableLastInt = (STABLE_CYCLES >= 2) ? (STABLE_CYCLES - 2) : 32'd0;
    localparam bit          DirectRun     = (STABLE_CYCLES <= 1);

    localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(StableLastInt);
    localparam logic [CNT_W-1:0] EnToRst     = CNT_W'(EN_TO_RST);
    localparam logic [3:0]       MaxRetry    = 4'(MAX_RETRY);

    // Lock synchroniser.
    logic lock_meta_q;
    logic lock_s_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Sequencer state.
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             lost_evt_q, lost_evt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StRstPll;
            cnt_q      <= '0;
            retry_q    <= '0;
            lost_evt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            lost_evt_q <= lost_evt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        retry_d    = retry_q;
        lost_evt_d = 1'b0;

        unique case (state_q)
            StRstPll: begin
                if (cnt_q == RstLast) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end
            end

            StWaitLock: begin
                if (lock_s_q) begin
                    cnt_d = '0;
                    if (DirectRun) begin
                        state_d = StRun;
                        retry_d = '0;
                    end else begin
                        state_d = StStable;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    cnt_d = '0;
                    if (retry_q == MaxRetry) begin
                        state_d = StFail;
                    end else begin
                        retry_d = retry_q + 4'd1;
                        state_d = StRstPll;
                    end
                end
            end

            StStable: begin
                if (!lock_s_q) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == StableLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end

            StRun: begin
                if (!lock_s_q || relock_req_i) begin
                    state_d    = StRstPll;
                    cnt_d      = '0;
                    lost_evt_d = !lock_s_q;
                end else if (cnt_q == EnToRst) begin
                    // Saturate so the camera reset stays released.
                    cnt_d = cnt_q;
                end
            end

            StFail: begin
                cnt_d = cnt_q;
                if (relock_req_i) begin
                    state_d = StRstPll;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end

            default: begin
                state_d = StRstPll;
                cnt_d   = '0;
            end
        endcase
    end

    // Output registers, all decoded from the current state so they change together.
    logic       pll_reset_q;
    logic       pll_enclk_q;
    logic       cam_rst_n_q;
    logic       ready_q;
    logic       fail_q;
    logic       lost_lock_q;
    logic [3:0] retry_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pll_reset_q <= 1'b1;
            pll_enclk_q <= 1'b0;
            cam_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            lost_lock_q <= 1'b0;
            retry_cnt_q <= '0;
        end else begin
            pll_reset_q <= (state_q == StRstPll) || (state_q == StFail);
            pll_enclk_q <= (state_q == StRun);
            cam_rst_n_q <= (state_q == StRun) && (cnt_q == EnToRst);
            ready_q     <= (state_q == StRun);
            fail_q      <= (state_q == StFail);
            lost_lock_q <= lost_evt_q;
            retry_cnt_q <= retry_q;
        end
    end

    assign pll_reset_o = pll_reset_q;
    assign pll_enclk_o = pll_enclk_q;
    assign cam_rst_n_o = cam_rst_n_q;
    assign ready_o     = ready_q;
    assign fail_o      = fail_q;
    assign lost_lock_o = lost_lock_q;
    assign retry_cnt_o = retry_cnt_q;

endmodule
